fifo_reg_reader: RTL and testbench
==================================

Name: fifo_reg_reader

Overview:
- Read side of the register-based FIFO path. Write-side producers deliver words with a write flag (i_wf, in_d).
- This block stores the words in a DEPTH-entry register array.
- It drains them in order to a downstream consumer over a valid/ready stream.
- A registered output stage holds each word stable until the consumer accepts it.

Parameters:
- DWIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries. Must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer index width. This is a derived value; do not override it.

Ports:
- clk  input  1  System clock. All state updates on the rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- i_wf  input  1  Write flag. When high, in_d is offered for storage this cycle.
- in_d  input  DWIDTH  Write data.
- ot_d  output  DWIDTH  Read data (registered).
- o_valid  output  1  ot_d holds an unconsumed word.
- i_ready  input  1  Consumer accepts ot_d this cycle when o_valid is also high.
- o_full  output  1  Storage holds DEPTH entries.
- o_empty  output  1  Storage holds 0 entries. The output stage may still be valid.
- o_count  output  AW+1  Storage occupancy, 0..DEPTH. Does not include the output stage.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - ot_d=0, o_valid=0, o_full=0, o_empty=1, o_count=0.
  - Write and read pointers (AW+1 bits each, wrap bit included) = 0.
  - The storage array is not reset.
  - Asserting reset mid-operation discards all stored and in-flight words immediately.
- Write:
  - A write is accepted when i_wf=1 and o_full=0 at the clock edge. in_d goes to mem[wr_ptr[AW-1:0]] and wr_ptr increments.
  - i_wf=1 while o_full=1 is dropped silently. Pointers and data are unchanged.
- Pop condition: the output stage loads when the storage is non-empty AND (o_valid=0 OR i_ready=1).
  - On load: ot_d <= mem[rd_ptr[AW-1:0]], o_valid <= 1, rd_ptr increments.
- Consume without reload: o_valid=1, i_ready=1 and storage empty gives o_valid <= 0. ot_d keeps its last value.
- Stall: o_valid=1 and i_ready=0 gives ot_d and o_valid unchanged. ot_d must not glitch or change while stalled.
- Latency:
  - A word written at edge k into an empty block (o_valid=0) appears with o_valid=1 after edge k+1.
  - There is no write-to-output bypass. Words always pass through storage.
- Throughput: 1 word/cycle sustained while storage is non-empty and i_ready=1.
- Simultaneous write and pop in the same cycle:
  - Both take effect.
  - o_count is unchanged.
  - o_full and o_empty are unchanged unless the count actually moves.
- Write while full: o_full is evaluated before the same-cycle pop. A write in a cycle where o_full=1 is dropped even if a pop frees a slot that cycle.
- Flags and count:
  - o_count = wr_ptr - rd_ptr, in AW+1-bit modulo arithmetic.
  - o_full = (pointer indices equal AND wrap bits differ).
  - o_empty = (pointers fully equal).
  - All three are registered, or derived from registered pointers only. No combinational path from i_wf or i_ready.
- Pointer wrap-around: the pointer index wraps DEPTH-1 -> 0 with the wrap bit toggling. There is no reset on wrap.
- Total words buffered: at most DEPTH+1 (storage plus output stage).

Optional Feature:
- Macro name: FIFO_REG_ERR_FLAG_EN.
- When defined, two extra outputs are added: o_ovf (1 bit) and o_udf (1 bit). Both are sticky, reset to 0, and are cleared only by rst_n.
  - o_ovf sets at the edge after a write attempt with o_full=1.
  - o_udf sets at the edge after i_ready=1 with o_valid=0 and o_empty=1 (consumer polled an idle block).
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
Use DWIDTH=8, DEPTH=4 for all scenarios.
- Reset and idle: hold rst_n=0, then release. Expect ot_d=0x00, o_valid=0, o_empty=1, o_full=0, o_count=0. Assert rst_n mid-burst; outputs return to these values asynchronously, without waiting for a clock edge.
- Single word: i_ready=0, write 0xA5 at edge k. Expect o_count=1 after edge k. After edge k+1, o_valid=1, ot_d=0xA5, o_count=0. Raise i_ready for 1 cycle; o_valid drops and ot_d stays 0xA5.
- Fill and overflow: i_ready=0, write 0x01..0x06 on consecutive cycles.
  - Storage accepts 0x01..0x05 (0x01 moves to the output stage, 4 remain) and o_full=1.
  - 0x06 is dropped.
  - With FIFO_REG_ERR_FLAG_EN defined, o_ovf=1.
  - Drain with i_ready=1: output sequence is exactly 0x01..0x05.
- Streaming: i_wf=1 and i_ready=1 continuously with data 0x10..0x1F.
  - Output is 0x10..0x1F in order, one per cycle after 2-cycle fill latency.
  - o_count stays at most 1; o_full never asserts.
- Backpressure: during streaming, drop i_ready for 3 cycles. Expect ot_d and o_valid stable throughout, o_count rising to 3, then draining with no loss or duplication.
- Wrap-around: push and pop 20 words (0x00..0x13) in bursts of 3. The pointers wrap 5 times, and the output order matches the input order exactly.

Source files
------------

// File: rtl/fifo_reg_reader.sv
// fifo_reg_reader: read side of the register-based FIFO path.
// Words written with i_wf/in_d land in a DEPTH-entry register array and are
// drained in order through a registered output stage (ot_d/o_valid).
//
// Handshake: a word on ot_d is transferred on a rising clk edge where
// o_valid=1 and i_ready=1. While o_valid=1 and i_ready=0, ot_d and o_valid
// hold their values. o_valid never depends combinationally on i_ready.
//
// Optional build macro: FIFO_REG_ERR_FLAG_EN adds sticky o_ovf / o_udf
// error outputs (write while full / consumer polled an idle block).
module fifo_reg_reader #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wf,
  input  logic [DWIDTH-1:0] in_d,
  output logic [DWIDTH-1:0] ot_d,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
`ifdef FIFO_REG_ERR_FLAG_EN
  ,
  output logic              o_ovf,
  output logic              o_udf
`endif
);

  // Storage array; deliberately not reset.
  logic [DWIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        wr_en;
  logic        pop;
  logic        consume;

  // Flags and occupancy come only from registered pointers.
  assign o_count = wr_ptr - rd_ptr;
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

  // Write uses the pre-edge full flag, so a same-cycle pop never rescues it.
  assign wr_en   = i_wf && !o_full;
  // Output stage reloads when storage has data and the stage is free or leaving.
  assign pop     = !o_empty && (!o_valid || i_ready);
  assign consume = o_valid && i_ready;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_d;
    end
  end

  // Pointer registers; index wraps naturally with the wrap bit toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Registered output stage: load on pop, drop valid on consume without reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ot_d    <= '0;
      o_valid <= 1'b0;
    end else begin
      if (pop) begin
        ot_d    <= mem[rd_ptr[AW-1:0]];
        o_valid <= 1'b1;
      end else if (consume) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_REG_ERR_FLAG_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (i_wf && o_full) begin
        o_ovf <= 1'b1;
      end
      if (i_ready && !o_valid && o_empty) begin
        o_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reg_reader.sv
// Directed testbench for fifo_reg_reader (DWIDTH=8, DEPTH=4).
module tb_fifo_reg_reader;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk;
  logic              rst_n;
  logic              i_wf;
  logic [DWIDTH-1:0] in_d;
  logic [DWIDTH-1:0] ot_d;
  logic              o_valid;
  logic              i_ready;
  logic              o_full;
  logic              o_empty;
  logic [AW:0]       o_count;
`ifdef FIFO_REG_ERR_FLAG_EN
  logic              o_ovf;
  logic              o_udf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DWIDTH-1:0] exp_q[$];
  logic [DWIDTH-1:0] got_q[$];

  fifo_reg_reader #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wf    (i_wf),
    .in_d    (in_d),
    .ot_d    (ot_d),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_count (o_count)
`ifdef FIFO_REG_ERR_FLAG_EN
    ,
    .o_ovf   (o_ovf),
    .o_udf   (o_udf)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with inputs idle; returns 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n   = 1'b0;
    i_wf    = 1'b0;
    i_ready = 1'b0;
    in_d    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
  endtask

  // Record the word transferred at the coming edge, then advance one cycle.
  task automatic tick();
    if (o_valid === 1'b1 && i_ready === 1'b1) got_q.push_back(ot_d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_wf    = 1'b0;
    i_ready = 1'b0;
    in_d    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ot_d, o_valid, o_empty, o_full, o_count} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_idle: ot_d=%h v=%b e=%b f=%b cnt=%0d, want 00 0 1 0 0",
               ot_d, o_valid, o_empty, o_full, o_count);
    end
`ifdef FIFO_REG_ERR_FLAG_EN
    n_cmp++;
    if ({o_ovf, o_udf} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_err_flags: ovf=%b udf=%b, want 0 0", o_ovf, o_udf);
    end
`endif
    // Start a burst, then reset asynchronously between edges.
    i_wf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_d = 8'h30 + 8'(i);
      @(posedge clk);
      #1;
    end
    i_wf = 1'b0;
    n_cmp++;
    if ({o_valid, ot_d, o_count} !== {1'b1, 8'h30, 3'd2}) begin
      n_err++;
      $display("FAIL burst_before_reset: v=%b ot_d=%h cnt=%0d, want 1 30 2",
               o_valid, ot_d, o_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ot_d, o_valid, o_empty, o_full, o_count} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL async_reset: ot_d=%h v=%b e=%b f=%b cnt=%0d, want 00 0 1 0 0",
               ot_d, o_valid, o_empty, o_full, o_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({o_valid, o_empty, o_count} !== {1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL after_reset_release: v=%b e=%b cnt=%0d, want 0 1 0",
               o_valid, o_empty, o_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    i_wf = 1'b1;
    in_d = 8'hA5;
    tick();
    i_wf = 1'b0;
    n_cmp++;
    if ({o_count, o_valid} !== {3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL single_stored: cnt=%0d v=%b, want 1 0", o_count, o_valid);
    end
    tick();
    n_cmp++;
    if ({o_valid, ot_d, o_count, o_empty} !== {1'b1, 8'hA5, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL single_out: v=%b ot_d=%h cnt=%0d e=%b, want 1 a5 0 1",
               o_valid, ot_d, o_count, o_empty);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_cmp++;
    if ({o_valid, ot_d} !== {1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL single_consume: v=%b ot_d=%h, want 0 a5", o_valid, ot_d);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    i_ready = 1'b0;
    i_wf    = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      in_d = 8'(v);
      tick();
    end
    i_wf = 1'b0;
    n_cmp++;
    if ({o_full, o_count, o_valid, ot_d} !== {1'b1, 3'd4, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL fill_full: f=%b cnt=%0d v=%b ot_d=%h, want 1 4 1 01",
               o_full, o_count, o_valid, ot_d);
    end
`ifdef FIFO_REG_ERR_FLAG_EN
    n_cmp++;
    if (o_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: ovf=%b, want 1", o_ovf);
    end
`endif
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    i_ready = 1'b1;
    repeat (7) tick();
    i_ready = 1'b0;
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL drain_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL drain_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({o_valid, o_empty, o_full} !== {1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL drain_idle: v=%b e=%b f=%b, want 0 1 0", o_valid, o_empty, o_full);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_wf = 1'b1;
      in_d = 8'h10 + 8'(i);
      exp_q.push_back(in_d);
      tick();
      n_cmp++;
      if (o_count > 3'd1 || o_full !== 1'b0) begin
        n_err++;
        $display("FAIL stream_level[%0d]: cnt=%0d f=%b, want cnt<=1 f=0", i, o_count, o_full);
      end
    end
    i_wf = 1'b0;
    // Two-cycle fill latency: 14 of 16 words transferred by now.
    n_cmp++;
    if (got_q.size() != 14) begin
      n_err++;
      $display("FAIL stream_rate: got %0d words after 16 cycles, want 14", got_q.size());
    end
    repeat (4) tick();
    i_ready = 1'b0;
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stream_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stream_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      i_wf    = 1'b1;
      in_d    = 8'h20 + 8'(i);
      i_ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
      exp_q.push_back(in_d);
      tick();
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if ({o_valid, ot_d} !== {1'b1, 8'h20}) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: v=%b ot_d=%h, want 1 20", i, o_valid, ot_d);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (o_count !== 3'd3) begin
          n_err++;
          $display("FAIL stall_count: cnt=%0d, want 3", o_count);
        end
      end
    end
    i_wf = 1'b0;
    repeat (8) tick();
    i_ready = 1'b0;
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int v;
    do_reset();
    v = 0;
    while (v < 20) begin
      i_ready = 1'b0;
      for (int j = 0; j < 3 && v < 20; j++) begin
        i_wf = 1'b1;
        in_d = 8'(v);
        exp_q.push_back(in_d);
        v++;
        tick();
      end
      i_wf    = 1'b0;
      i_ready = 1'b1;
      repeat (5) tick();
      i_ready = 1'b0;
      n_cmp++;
      if ({o_valid, o_empty, o_count} !== {1'b0, 1'b1, 3'd0}) begin
        n_err++;
        $display("FAIL wrap_burst_drained(v=%0d): v=%b e=%b cnt=%0d, want 0 1 0",
                 v, o_valid, o_empty, o_count);
      end
    end
    n_cmp++;
    if (got_q.size() != 20) begin
      n_err++;
      $display("FAIL wrap_count: got %0d words, want 20", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL wrap_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef FIFO_REG_ERR_FLAG_EN
  task automatic test_err_flags();
    do_reset();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_cmp++;
    if ({o_udf, o_ovf} !== 2'b10) begin
      n_err++;
      $display("FAIL udf_flag: udf=%b ovf=%b, want 1 0", o_udf, o_ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_backpressure();
    test_wrap();
`ifdef FIFO_REG_ERR_FLAG_EN
    test_err_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
